int_ram_pingpong_ctrl: RTL and testbench

- Owns the single access port of the two-bank (ping-pong) intrinsic-LLR RAM in the LDPC decoder.
- Shares that port between a frame writer (channel LLR loader) and a frame reader (decoder core).
- Tracks which bank holds a complete frame, so the loader fills one bank while the decoder iterates on the other.
- All RAM control signals (address, data, we, cs, bank select rs) are driven by this block.

---
 rtl/int_ram_pingpong_ctrl.sv | 165 ++++++++++++++++
 tb/tb_int_ram_pingpong_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ram_pingpong_ctrl.sv
// Ping-pong intrinsic-LLR RAM port controller: arbitrates one RAM port between
// the frame loader and the decoder core and tracks per-bank frame ownership.
// Optional statistics outputs are enabled with the INT_RAM_CTRL_STATS_EN macro.
module int_ram_pingpong_ctrl #(
    parameter int DATA_WIDTH = 5,
    parameter int ADDR_WIDTH = 8,
    parameter int FRAME_LEN  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_gnt,
    output logic                  wr_ready,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    input  logic                  rd_release,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  frame_ready,
    output logic                  release_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    output logic                  ram_cs,
    output logic                  ram_rs,
    input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef INT_RAM_CTRL_STATS_EN
    ,
    output logic [15:0]           frames_loaded,
    output logic [15:0]           wr_stall_cnt
`endif
);

    localparam logic [1:0] EMPTY   = 2'd0;
    localparam logic [1:0] FILLING = 2'd1;
    localparam logic [1:0] FULL    = 2'd2;

    localparam int              CNT_W = ADDR_WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    logic [1:0][1:0]  bank_q, bank_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             last_srv_q, last_srv_d;
    logic             rd_valid_q;
    logic             release_err_q;

    logic wr_elig;
    logic rd_elig;
    logic frame_done;
    logic rel_ok;

    // Eligibility, round-robin arbitration and status flags
    always_comb begin
        wr_ready    = (bank_q[wr_bank_q] != FULL);
        frame_ready = (bank_q[rd_bank_q] == FULL);
        wr_elig     = wr_req && wr_ready;
        rd_elig     = rd_req && frame_ready;
        wr_gnt      = wr_elig && (!rd_elig || last_srv_q);
        rd_gnt      = rd_elig && (!wr_elig || !last_srv_q);
        frame_done  = wr_gnt && (wr_cnt_q == LAST);
        rel_ok      = rd_release && frame_ready;
    end

    // RAM port mux: idle port drives zeros
    always_comb begin
        ram_cs   = 1'b0;
        ram_we   = 1'b0;
        ram_rs   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (wr_gnt) begin
            ram_cs   = 1'b1;
            ram_we   = 1'b1;
            ram_rs   = wr_bank_q;
            ram_addr = wr_addr;
            ram_din  = wr_data;
        end else if (rd_gnt) begin
            ram_cs   = 1'b1;
            ram_rs   = rd_bank_q;
            ram_addr = rd_addr;
        end
    end

    // Bank ownership, pointers, fill counter and arbitration history
    always_comb begin
        bank_d     = bank_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_cnt_d   = wr_cnt_q;
        last_srv_d = last_srv_q;
        if (wr_gnt) begin
            last_srv_d = 1'b0;
            if (frame_done) begin
                bank_d[wr_bank_q] = FULL;
                wr_bank_d         = ~wr_bank_q;
                wr_cnt_d          = '0;
            end else begin
                bank_d[wr_bank_q] = FILLING;
                wr_cnt_d          = wr_cnt_q + CNT_W'(1);
            end
        end
        if (rd_gnt) begin
            last_srv_d = 1'b1;
        end
        // A full reader bank is never the writer bank, so no conflict here
        if (rel_ok) begin
            bank_d[rd_bank_q] = EMPTY;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q        <= {EMPTY, EMPTY};
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_cnt_q      <= '0;
            last_srv_q    <= 1'b1;
            rd_valid_q    <= 1'b0;
            release_err_q <= 1'b0;
        end else begin
            bank_q        <= bank_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            wr_cnt_q      <= wr_cnt_d;
            last_srv_q    <= last_srv_d;
            rd_valid_q    <= rd_gnt;
            release_err_q <= rd_release && !frame_ready;
        end
    end

    assign rd_valid    = rd_valid_q;
    assign release_err = release_err_q;
    assign rd_data     = ram_dout;

`ifdef INT_RAM_CTRL_STATS_EN
    logic [15:0] frames_q;
    logic [15:0] stall_q;

    // Saturating frame and writer-stall counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_q <= '0;
            stall_q  <= '0;
        end else begin
            if (frame_done && frames_q != 16'hFFFF) begin
                frames_q <= frames_q + 16'd1;
            end
            if (wr_req && !wr_gnt && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign frames_loaded = frames_q;
    assign wr_stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_int_ram_pingpong_ctrl.sv
// Bench for int_ram_pingpong_ctrl: directed scenarios plus random traffic
// checked against a queue-based frame-ownership model and a reference memory.
module tb_int_ram_pingpong_ctrl;
    localparam int DW = 5;
    localparam int AW = 8;
    localparam int FL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_gnt;
    logic          wr_ready;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_gnt;
    logic          rd_release = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          frame_ready;
    logic          release_err;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic          ram_cs;
    logic          ram_rs;
    logic [DW-1:0] ram_dout;
`ifdef INT_RAM_CTRL_STATS_EN
    logic [15:0]   frames_loaded;
    logic [15:0]   wr_stall_cnt;
`endif

    always #5 clk = ~clk;

    int_ram_pingpong_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .FRAME_LEN (FL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_gnt     (wr_gnt),
        .wr_ready   (wr_ready),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_release (rd_release),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .frame_ready(frame_ready),
        .release_err(release_err),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_cs     (ram_cs),
        .ram_rs     (ram_rs),
        .ram_dout   (ram_dout)
`ifdef INT_RAM_CTRL_STATS_EN
        ,
        .frames_loaded(frames_loaded),
        .wr_stall_cnt (wr_stall_cnt)
`endif
    );

    // Two-bank synchronous RAM
    logic [DW-1:0] ram [0:511];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) ram[{ram_rs, ram_addr}] <= ram_din;
            else ram_dout <= ram[{ram_rs, ram_addr}];
        end
    end

    // Reference model: queue of completed banks (oldest first)
    int            m_full[$];
    int            m_wb;
    int            m_fill;
    bit            m_rd_last;
    logic [DW-1:0] ref_mem [0:1][0:255];

    bit            e_wg, e_rg, e_wrdy, e_frdy, e_rs;
    logic [AW-1:0] e_addr;
    bit            e_vld, e_err;
    logic [DW-1:0] e_rdata;

    int vecs = 0;
    int errs = 0;

    task automatic eval();
        bit wok, rok, we, re;
        wok    = m_full.size() < 2;
        rok    = m_full.size() > 0;
        we     = wr_req && wok;
        re     = rd_req && rok;
        e_wrdy = wok;
        e_frdy = rok;
        e_wg   = we && (!re || m_rd_last);
        e_rg   = re && !e_wg;
        e_rs   = 1'b0;
        e_addr = '0;
        if (e_wg) begin
            e_rs   = m_wb[0];
            e_addr = wr_addr;
        end else if (e_rg) begin
            e_rs   = m_full[0][0];
            e_addr = rd_addr;
        end
    endtask

    task automatic tick();
        bit rok;
        eval();
        rok   = m_full.size() > 0;
        e_vld = e_rg;
        if (e_rg) e_rdata = ref_mem[m_full[0]][rd_addr];
        e_err = rd_release && !rok;
        if (e_wg) begin
            ref_mem[m_wb][wr_addr] = wr_data;
            m_rd_last = 1'b0;
            m_fill++;
        end
        if (e_rg) m_rd_last = 1'b1;
        if (rd_release && rok) m_full.delete(0);
        if (e_wg && m_fill == FL) begin
            m_full.push_back(m_wb);
            m_wb   = 1 - m_wb;
            m_fill = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_full.delete();
        m_wb      = 0;
        m_fill    = 0;
        m_rd_last = 1'b1;
        e_vld     = 1'b0;
        e_err     = 1'b0;
    endtask

    task automatic drive(bit wq, int wa, int wd, bit rq, int ra, bit rl);
        wr_req     = wq;
        wr_addr    = AW'(wa);
        wr_data    = DW'(wd);
        rd_req     = rq;
        rd_addr    = AW'(ra);
        rd_release = rl;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        model_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic write_frames(int n);
        for (int i = 0; i < n; i++) begin
            drive(1, i % FL, (i % FL) + 1, 0, 0, 0);
            #2;
            vecs++;
            if (wr_gnt !== 1'b1) begin
                errs++;
                $display("FAIL fill_gnt i=%0d got %b exp 1", i, wr_gnt);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #2;
        vecs++;
        if ({wr_gnt, rd_gnt, wr_ready, frame_ready, rd_valid, release_err, ram_cs}
            !== 7'b0010000) begin
            errs++;
            $display("FAIL reset_outs got %b exp 0010000",
                     {wr_gnt, rd_gnt, wr_ready, frame_ready, rd_valid, release_err, ram_cs});
        end
        model_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_first_frame();
        for (int i = 0; i < FL; i++) begin
            drive(1, i, i + 1, 0, 0, 0);
            #2;
            vecs++;
            if ({wr_gnt, ram_cs, ram_we, ram_rs, frame_ready} !== 5'b11100
                || ram_addr !== AW'(i) || ram_din !== DW'(i + 1)) begin
                errs++;
                $display("FAIL frame_wr i=%0d got %b a=%0d d=%0d", i,
                         {wr_gnt, ram_cs, ram_we, ram_rs, frame_ready}, ram_addr, ram_din);
            end
            tick();
        end
        drive(1, 16, 7, 0, 0, 0);
        #2;
        vecs++;
        if ({frame_ready, wr_ready, wr_gnt, ram_rs} !== 4'b1111) begin
            errs++;
            $display("FAIL frame_done got %b exp 1111",
                     {frame_ready, wr_ready, wr_gnt, ram_rs});
        end
        tick();
    endtask

    task automatic test_read();
        drive(0, 0, 0, 1, 2, 0);
        #2;
        vecs++;
        if ({rd_gnt, ram_cs, ram_we, ram_rs} !== 4'b1100 || ram_addr !== 8'd2) begin
            errs++;
            $display("FAIL rd_issue got %b a=%0d", {rd_gnt, ram_cs, ram_we, ram_rs}, ram_addr);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #2;
        vecs++;
        if (rd_valid !== 1'b1 || rd_data !== 5'd3) begin
            errs++;
            $display("FAIL rd_data got v=%b d=%0d exp v=1 d=3", rd_valid, rd_data);
        end
        tick();
        for (int k = 0; k <= FL; k++) begin
            drive(0, 0, 0, k < FL, k, 0);
            #2;
            if (k > 0) begin
                vecs++;
                if (rd_valid !== 1'b1 || rd_data !== DW'(k)) begin
                    errs++;
                    $display("FAIL rd_b2b k=%0d got v=%b d=%0d exp d=%0d",
                             k, rd_valid, rd_data, k);
                end
            end
            tick();
        end
    endtask

    task automatic test_contention();
        do_reset();
        write_frames(FL);
        for (int i = 0; i < 8; i++) begin
            drive(1, i + 32, i + 9, 1, i % FL, 0);
            #2;
            eval();
            vecs++;
            if ({wr_gnt, rd_gnt} !== {e_wg, e_rg}) begin
                errs++;
                $display("FAIL contend i=%0d got %b exp %b", i, {wr_gnt, rd_gnt}, {e_wg, e_rg});
            end
            tick();
        end
    endtask

    task automatic test_both_full();
        do_reset();
        write_frames(2 * FL);
        drive(1, 5, 5, 0, 0, 0);
        #2;
        vecs++;
        if ({wr_ready, wr_gnt, frame_ready} !== 3'b001) begin
            errs++;
            $display("FAIL full_stall got %b exp 001", {wr_ready, wr_gnt, frame_ready});
        end
        tick();
        drive(1, 5, 5, 0, 0, 1);
        #2;
        tick();
        drive(1, 6, 6, 0, 0, 0);
        #2;
        vecs++;
        if ({frame_ready, wr_ready, wr_gnt, ram_rs, release_err} !== 5'b11100) begin
            errs++;
            $display("FAIL full_release got %b exp 11100",
                     {frame_ready, wr_ready, wr_gnt, ram_rs, release_err});
        end
        tick();
    endtask

    task automatic test_release_err();
        do_reset();
        drive(0, 0, 0, 0, 0, 1);
        #2;
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #2;
        vecs++;
        if ({release_err, wr_ready, frame_ready} !== 3'b110) begin
            errs++;
            $display("FAIL rel_err got %b exp 110", {release_err, wr_ready, frame_ready});
        end
        tick();
        #2;
        vecs++;
        if (release_err !== 1'b0) begin
            errs++;
            $display("FAIL rel_err_pulse got %b exp 0", release_err);
        end
        tick();
    endtask

    task automatic test_rst_midframe();
        do_reset();
        write_frames(FL + 2);
        drive(0, 0, 0, 1, 1, 0);
        #2;
        tick();
        rst = 1'b1;
        #1;
        vecs++;
        if ({rd_valid, frame_ready, wr_ready, rd_gnt} !== 4'b0010) begin
            errs++;
            $display("FAIL rst_mid got %b exp 0010", {rd_valid, frame_ready, wr_ready, rd_gnt});
        end
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < FL; i++) begin
            drive(1, i, i + 20, 0, 0, 0);
            #2;
            vecs++;
            if ({wr_gnt, ram_rs, frame_ready} !== 3'b100) begin
                errs++;
                $display("FAIL rst_refill i=%0d got %b exp 100", i, {wr_gnt, ram_rs, frame_ready});
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        #2;
        vecs++;
        if (frame_ready !== 1'b1) begin
            errs++;
            $display("FAIL rst_refill_done got %b exp 1", frame_ready);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(99) < 60, $urandom_range(255), $urandom_range(31),
                  $urandom_range(99) < 60, $urandom_range(255), $urandom_range(99) < 8);
            #2;
            eval();
            vecs++;
            if ({wr_gnt, rd_gnt, wr_ready, frame_ready} !== {e_wg, e_rg, e_wrdy, e_frdy}) begin
                errs++;
                $display("FAIL rnd_ctl i=%0d got %b exp %b", i,
                         {wr_gnt, rd_gnt, wr_ready, frame_ready}, {e_wg, e_rg, e_wrdy, e_frdy});
            end
            vecs++;
            if ({ram_cs, ram_we, ram_rs} !== {e_wg | e_rg, e_wg, e_rs} || ram_addr !== e_addr
                || ram_din !== (e_wg ? wr_data : '0)) begin
                errs++;
                $display("FAIL rnd_ram i=%0d got %b a=%0d exp %b a=%0d", i,
                         {ram_cs, ram_we, ram_rs}, ram_addr, {e_wg | e_rg, e_wg, e_rs}, e_addr);
            end
            vecs++;
            if (rd_valid !== e_vld || (e_vld && rd_data !== e_rdata)) begin
                errs++;
                $display("FAIL rnd_rd i=%0d got v=%b d=%0d exp v=%b d=%0d", i,
                         rd_valid, rd_data, e_vld, e_rdata);
            end
            vecs++;
            if (release_err !== e_err) begin
                errs++;
                $display("FAIL rnd_relerr i=%0d got %b exp %b", i, release_err, e_err);
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = '0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 256; a++) ref_mem[b][a] = '0;
        ram_dout = '0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_first_frame();
        test_read();
        test_contention();
        test_both_full();
        test_release_err();
        test_rst_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
